// File: rtl/coffee_credit_if.sv
// Payment bus between the coin front-end, the brewer and the change dispenser.
interface coffee_credit_if #(
  parameter int W = 8
);
  logic         on;
  logic         coin_valid;
  logic [1:0]   coin_type;
  logic         cancel;
  logic         served;
  logic         change_ack;
  logic         gen;
  logic [W-1:0] credit;
  logic         change_valid;
  logic [W-1:0] change_amount;
  logic         coin_reject;

  // Machine side: drives coins/commands, receives brew request and change.
  modport master (
    output on, coin_valid, coin_type, cancel, served, change_ack,
    input  gen, credit, change_valid, change_amount, coin_reject
  );

  // Payment block side.
  modport slave (
    input  on, coin_valid, coin_type, cancel, served, change_ack,
    output gen, credit, change_valid, change_amount, coin_reject
  );
endinterface

// File: rtl/coffee_credit.sv
// Coin credit accumulator: raises gen once credit covers PRICE, waits for
// served, then pays out any excess through a valid/ack change handshake.
// Moore machine: every output is a register or a decode of the state.
module coffee_credit #(
  parameter int W     = 8,
  parameter int PRICE = 30,
  parameter int COIN0 = 5,
  parameter int COIN1 = 10,
  parameter int COIN2 = 20,
  parameter int COIN3 = 50
) (
  input  logic           clock,
  input  logic           reset,
  coffee_credit_if.slave bus
);
  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_READY   = 3'd3;
  localparam logic [2:0] S_REFUND  = 3'd4;

  // Arithmetic runs at 32 bits so credit+coin never wraps before saturation.
  localparam logic [31:0] MAXC    = (32'd1 << W) - 32'd1;
  localparam logic [31:0] PRICE32 = 32'(PRICE);

  logic [2:0]   r_state, w_state_nx;
  logic [W-1:0] r_credit, w_credit_nx;
  logic [W-1:0] r_change, w_change_nx;
  logic         r_coin_reject, w_reject;

  logic [31:0]  w_coin_val;
  logic [31:0]  w_sum;
  logic [31:0]  w_sum_sat;
  logic [31:0]  w_total;
  logic [31:0]  w_excess;
  logic [W-1:0] w_add;

  // Coin denomination lookup.
  always_comb begin
    w_coin_val = 32'(COIN0);
    case (bus.coin_type)
      2'b00:   w_coin_val = 32'(COIN0);
      2'b01:   w_coin_val = 32'(COIN1);
      2'b10:   w_coin_val = 32'(COIN2);
      default: w_coin_val = 32'(COIN3);
    endcase
  end

  // Saturating credit + coin, and the excess over PRICE when served.
  // A coin landing in the same cycle as served still counts toward change.
  always_comb begin
    w_sum     = 32'(r_credit) + w_coin_val;
    w_sum_sat = (w_sum > MAXC) ? MAXC : w_sum;
    w_add     = w_sum_sat[W-1:0];
    w_total   = bus.coin_valid ? w_sum_sat : 32'(r_credit);
    w_excess  = w_total - PRICE32;
  end

  // Next-state / next-credit decision. A strobed coin is rejected unless a
  // branch below explicitly takes it.
  always_comb begin
    w_state_nx  = r_state;
    w_credit_nx = r_credit;
    w_change_nx = r_change;
    w_reject    = bus.coin_valid;
    case (r_state)
      S_OFF: begin
        w_credit_nx = '0;
        if (bus.on) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        w_credit_nx = '0;
        // Power-down wins over a coin; the coin is bounced.
        if (!bus.on) begin
          w_state_nx = S_OFF;
        end else if (bus.coin_valid) begin
          w_reject    = 1'b0;
          w_credit_nx = w_add;
          w_state_nx  = (w_sum_sat >= PRICE32) ? S_READY : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (!bus.on || bus.cancel) begin
          w_state_nx  = S_REFUND;
          w_change_nx = r_credit;
        end else if (bus.coin_valid) begin
          w_reject    = 1'b0;
          w_credit_nx = w_add;
          if (w_sum_sat >= PRICE32) w_state_nx = S_READY;
        end
      end
      S_READY: begin
        if (bus.served) begin
          w_reject = 1'b0;
          if (w_excess != 32'd0) begin
            // Credit tracks the balance still owed while refunding.
            w_state_nx  = S_REFUND;
            w_change_nx = w_excess[W-1:0];
            w_credit_nx = w_excess[W-1:0];
          end else begin
            w_credit_nx = '0;
            w_state_nx  = bus.on ? S_IDLE : S_OFF;
          end
        end else if (bus.cancel || !bus.on) begin
          w_state_nx  = S_REFUND;
          w_change_nx = r_credit;
        end else if (bus.coin_valid) begin
          w_reject    = 1'b0;
          w_credit_nx = w_add;
        end
      end
      S_REFUND: begin
        // change_amount holds until the dispenser takes it.
        if (bus.change_ack) begin
          w_credit_nx = '0;
          w_change_nx = '0;
          w_state_nx  = bus.on ? S_IDLE : S_OFF;
        end
      end
      default: begin
        w_state_nx  = S_OFF;
        w_credit_nx = '0;
        w_change_nx = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending credit silently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_OFF;
      r_credit      <= '0;
      r_change      <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_credit      <= w_credit_nx;
      r_change      <= w_change_nx;
      r_coin_reject <= w_reject;
    end
  end

  assign bus.gen           = (r_state == S_READY);
  assign bus.change_valid  = (r_state == S_REFUND);
  assign bus.credit        = r_credit;
  assign bus.change_amount = r_change;
  assign bus.coin_reject   = r_coin_reject;
endmodule
